dm_port_arbiter: RTL and testbench

Single-port data-memory arbiter that shares the 256-word DATA_MEMORY between the CPU MEM stage and the host loader, which preloads GCD operands and reads back results. It sits between the MEM pipeline stage and the memory macro. It drives the memory's write enable, address and write data, stalls the pipeline when the host takes the port, and returns host read data through a request/acknowledge handshake.

---
 rtl/dm_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_dm_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter
// Brief    : Shares the single-port data memory between the CPU MEM stage and
//            the host loader. Optional DM_ARB_STARVE_LIMIT_EN forces a host
//            grant after HOST_MAX_WAIT consecutive denied cycles.
// Revision : 1.0 - initial release
// ============================================================================
module dm_port_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 32,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_run,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              bsy,
    output logic              dm_wea,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    input  logic [DATA_W-1:0] dm_dout
);

    typedef enum logic [1:0] {
        H_IDLE  = 2'd0,
        H_RDATA = 2'd1,
        H_ACK   = 2'd2
    } hst_t;

    hst_t              hst_q, hst_d;
    logic              host_ack_q, host_ack_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              cpu_acc;
    logic              host_pend;
    logic              hg;
    logic              unused_cpu_addr;

    // Byte offset and bits above the memory depth alias onto the same word.
    assign unused_cpu_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    assign cpu_acc   = cpu_rd | cpu_wr;
    assign host_pend = host_req & (hst_q == H_IDLE) & ~rst;

`ifdef DM_ARB_STARVE_LIMIT_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       starved;

    assign starved = (wait_cnt_q == 4'(HOST_MAX_WAIT));
    assign hg      = host_pend & (~cpu_run | ~cpu_acc | starved);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (hg || !host_pend) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign hg = host_pend & (~cpu_run | ~cpu_acc);
`endif

    // Port mux: the CPU owns the port unless the host is granted this cycle.
    always_comb begin
        dm_addr   = cpu_addr[ADDR_W+1:2];
        dm_din    = cpu_wdata;
        dm_wea    = cpu_wr & ~cpu_rd & cpu_run;
        cpu_stall = 1'b0;
        bsy       = 1'b1;
        if (rst) begin
            dm_addr = '0;
            dm_wea  = 1'b0;
        end else if (hg) begin
            dm_addr   = host_addr;
            dm_din    = host_wdata;
            dm_wea    = host_we;
            cpu_stall = cpu_acc & cpu_run;
            bsy       = 1'b0;
        end
    end

    always_comb begin
        hst_d        = hst_q;
        host_rdata_d = host_rdata_q;
        unique case (hst_q)
            H_IDLE: begin
                if (hg) begin
                    hst_d = host_we ? H_ACK : H_RDATA;
                end
            end
            H_RDATA: begin
                host_rdata_d = dm_dout;
                hst_d        = H_ACK;
            end
            H_ACK: begin
                hst_d = H_IDLE;
            end
            default: begin
                hst_d = H_IDLE;
            end
        endcase
        host_ack_d = (hst_d == H_ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hst_q        <= H_IDLE;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            hst_q        <= hst_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign cpu_rdata  = dm_dout;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_port_arbiter
// Brief    : Scoreboard bench for dm_port_arbiter with a synchronous-read
//            memory model attached to the dm_* port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

    localparam int HMW = 4;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        int          due;
    } hexp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_run, cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        host_req, host_we;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        host_ack, bsy, dm_wea;
    logic [7:0]  dm_addr;
    logic [31:0] dm_din;
    logic [31:0] dm_dout = '0;

    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        ld_issue = 1'b0;
    logic        ld_due = 1'b0;
    hexp_t       hq[$];
    logic [31:0] cq[$];

    dm_port_arbiter #(
        .ADDR_W        (8),
        .DATA_W        (32),
        .HOST_MAX_WAIT (HMW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_run    (cpu_run),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .bsy        (bsy),
        .dm_wea     (dm_wea),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_dout    (dm_dout)
    );

    initial forever #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (dm_wea) mem[dm_addr] <= dm_din;
        dm_dout <= mem[dm_addr];
        cyc     <= cyc + 1;
        ld_due  <= ld_issue;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_host(input logic rd, input logic [31:0] data, input int due);
        hexp_t e;
        e.rd   = rd;
        e.data = data;
        e.due  = due;
        hq.push_back(e);
    endtask

    // Host access with the CPU not contending: granted in the cycle it is raised.
    task automatic host_op(input logic we, input logic [7:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd);
        tick();
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
        #1;
        check("h_bsy", 32'(bsy), 32'd0);
        check("h_dm_addr", 32'(dm_addr), 32'(a));
        check("h_dm_wea", 32'(dm_wea), 32'(we));
        if (we) check("h_dm_din", dm_din, wd);
        push_host(~we, exp_rd, cyc + (we ? 1 : 2));
        tick();
        if (!we) tick();
        host_req = 1'b0;
    endtask

    task automatic cpu_load(input logic [31:0] addr, input logic [7:0] exp_word,
                            input logic [31:0] exp_data);
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = addr;
        #1;
        check("ld_dm_addr", 32'(dm_addr), 32'(exp_word));
        check("ld_stall", 32'(cpu_stall), 32'd0);
        ld_issue = 1'b1;
        cq.push_back(exp_data);
        tick();
        ld_issue = 1'b0;
        cpu_rd   = 1'b0;
    endtask

    // Scoreboard: host acks must arrive on their due cycle with the right data.
    always @(negedge clk) begin
        hexp_t e;
        if (ld_due) begin
            if (cq.size() == 0) check("cpu_q_underflow", 32'(cq.size()), 32'd1);
            else check("cpu_rdata", cpu_rdata, cq.pop_front());
        end
        if (host_ack) begin
            if (hq.size() == 0) begin
                check("host_ack_unexp", 32'(host_ack), 32'd0);
            end else begin
                e = hq.pop_front();
                check("host_ack_cyc", 32'(cyc), 32'(e.due));
                if (e.rd) check("host_rdata", host_rdata, e.data);
            end
        end else if (hq.size() != 0 && cyc >= hq[0].due) begin
            check("host_ack_missing", 32'(host_ack), 32'd1);
            void'(hq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cpu_run = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b1;
        cpu_addr = 32'h1C; cpu_wdata = 32'h1234_5678;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h33; host_wdata = 32'h0;
        repeat (3) tick();
        check("rst_dm_wea", 32'(dm_wea), 32'd0);
        check("rst_dm_addr", 32'(dm_addr), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_bsy", 32'(bsy), 32'd1);
        rst = 1'b0; cpu_run = 1'b0; cpu_wr = 1'b0; host_req = 1'b0;
        #1;
        check("rst_host_ack", 32'(host_ack), 32'd0);
        check("rst_host_rdata", host_rdata, 32'd0);

        // Host write then read-back with the CPU held.
        host_op(1'b1, 8'd0, 32'h0000_0024, 32'h0);
        host_op(1'b0, 8'd0, 32'h0, 32'h0000_0024);

        // CPU store, load, and aliased load.
        cpu_run = 1'b1;
        tick();
        cpu_wr = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
        #1;
        check("st_dm_wea", 32'(dm_wea), 32'd1);
        check("st_dm_addr", 32'(dm_addr), 32'd4);
        check("st_bsy", 32'(bsy), 32'd1);
        check("st_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_load(32'h10, 8'd4, 32'hDEAD_BEEF);
        cpu_load(32'h413, 8'd4, 32'hDEAD_BEEF);

        // Read+write together behaves as a read only.
        cpu_run = 1'b0;
        host_op(1'b1, 8'd8, 32'h5, 32'h0);
        cpu_run = 1'b1;
        tick();
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hFFFF_FFFF;
        #1;
        check("rw_dm_wea", 32'(dm_wea), 32'd0);
        check("rw_dm_addr", 32'(dm_addr), 32'd8);
        ld_issue = 1'b1;
        cq.push_back(32'h5);
        tick();
        ld_issue = 1'b0; cpu_wr = 1'b0;
        cpu_load(32'h20, 8'd8, 32'h5);

        // Contention: CPU loads every cycle while a host read is pending.
        tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'd0;
        cpu_rd = 1'b1; cpu_addr = 32'h10;
`ifdef DM_ARB_STARVE_LIMIT_EN
        for (int i = 0; i < HMW; i++) begin
            #1;
            check("c_deny_stall", 32'(cpu_stall), 32'd0);
            check("c_deny_bsy", 32'(bsy), 32'd1);
            ld_issue = 1'b1;
            cq.push_back(32'hDEAD_BEEF);
            tick();
        end
        ld_issue = 1'b0;
        #1;
        check("c_force_stall", 32'(cpu_stall), 32'd1);
        check("c_force_bsy", 32'(bsy), 32'd0);
        check("c_force_addr", 32'(dm_addr), 32'd0);
        push_host(1'b1, 32'h24, cyc + 2);
        tick();
        #1;
        check("c_retry_stall", 32'(cpu_stall), 32'd0);
        check("c_retry_addr", 32'(dm_addr), 32'd4);
        ld_issue = 1'b1;
        cq.push_back(32'hDEAD_BEEF);
        tick();
        ld_issue = 1'b0; cpu_rd = 1'b0; host_req = 1'b0;
`else
        for (int i = 0; i < 8; i++) begin
            #1;
            check("c_deny_stall", 32'(cpu_stall), 32'd0);
            check("c_deny_bsy", 32'(bsy), 32'd1);
            ld_issue = 1'b1;
            cq.push_back(32'hDEAD_BEEF);
            tick();
        end
        ld_issue = 1'b0; cpu_rd = 1'b0;
        #1;
        check("c_free_bsy", 32'(bsy), 32'd0);
        check("c_free_addr", 32'(dm_addr), 32'd0);
        check("c_free_stall", 32'(cpu_stall), 32'd0);
        push_host(1'b1, 32'h24, cyc + 2);
        tick();
        tick();
        host_req = 1'b0;
`endif

        // Reset during the data-capture cycle of a host read.
        cpu_run = 1'b0;
        tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'd8;
        #1;
        check("rr_grant_bsy", 32'(bsy), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("rr_rst_bsy", 32'(bsy), 32'd1);
        check("rr_rst_addr", 32'(dm_addr), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rr_rdata_cleared", host_rdata, 32'd0);
        check("rr_regrant_bsy", 32'(bsy), 32'd0);
        check("rr_regrant_addr", 32'(dm_addr), 32'd8);
        push_host(1'b1, 32'h5, cyc + 2);
        tick();
        tick();
        host_req = 1'b0;

        repeat (4) tick();
        check("host_q_empty", 32'(hq.size()), 32'd0);
        check("cpu_q_empty", 32'(cq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
